// File: rtl/data_mem_resp.sv
// data_mem_resp: multi-cycle word memory with byte-lane stores and a stall/ack handshake
module data_mem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem [2**DEPTH_LOG2];
  logic                  fin;
  logic                  unused_addr;
  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};
  assign fin = state == BUSY && cnt == 4'd0;
  assign stall_o = !rst && ((state == IDLE && ce_i) || state == BUSY);
  // Handshake FSM: capture in IDLE, count wait states in BUSY, complete in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      data_o <= 32'd0;
      ack_o  <= 1'b0;
    end else begin
      ack_o <= fin;
      if (state == IDLE && ce_i) begin
        state   <= BUSY;
        cnt     <= 4'(WAIT_CYCLES - 1);
        we_q    <= we_i;
        idx_q   <= addr_i[DEPTH_LOG2+1:2];
        sel_q   <= sel_i;
        wdata_q <= data_i;
      end else if (state == BUSY) begin
        state <= fin ? DONE : BUSY;
        cnt   <= fin ? cnt : cnt - 4'd1;
      end else if (state == DONE) begin
        state <= IDLE;
      end
      if (fin && !we_q) data_o <= mem[idx_q];
    end
  end
  // Store commit on the BUSY->DONE edge; memory itself is never reset
  always_ff @(posedge clk) begin
    if (!rst && fin && we_q)
      for (int i = 0; i < 4; i++)
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench for data_mem_resp handshake, lanes, aliasing, reset and flush
module tb_data_mem_resp;
  localparam int W = 2;
  logic        clk = 0;
  logic        rst = 1;
  logic        ce = 0;
  logic        we = 0;
  logic [31:0] addr = 0;
  logic [3:0]  sel = 0;
  logic [31:0] data = 0;
  logic [31:0] data_o;
  logic        stall, ack;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_load = 0;
  logic [31:0] exp_q [$];
  int          t1, t2;

  data_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(data), .data_o(data_o), .stall_o(stall), .ack_o(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp, input bit drop);
    int n_stall, t_ack;
    @(negedge clk);
    ce = 1; we = w; addr = a; sel = s; data = d;
    if (!w) exp_q.push_back(exp);
    n_stall = 0;
    t_ack = -1;
    for (int k = 0; k < 20 && t_ack < 0; k++) begin
      #1;
      if (ack) begin
        t_ack = k;
        ce = 0;
      end else begin
        if (stall) n_stall++;
        @(negedge clk);
        if (drop && k == 0) ce = 0;
      end
    end
    if (t_ack < 0) begin
      chk("ack_timeout", 32'd0, 32'd1);
      ce = 0;
      exp_q.delete();
      return;
    end
    chk("ack_cycle", t_ack, W + 1);
    chk("stall_cycles", n_stall, W + 1);
    chk("stall_in_done", {31'd0, stall}, 32'd0);
    if (w) chk("store_keeps_data_o", data_o, last_load);
    else begin
      last_load = exp_q.pop_front();
      chk("load_data", data_o, last_load);
    end
    @(negedge clk);
    #1;
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);
  endtask

  initial begin
    ce = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    ce = 0;
    rst = 0;

    access(1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0);
    access(0, 32'h10, 4'hF, 0, 32'hDEADBEEF, 0);

    access(1, 32'h20, 4'hF, 32'h11223344, 0, 0);
    access(1, 32'h20, 4'b0100, 32'hAAAAAAAA, 0, 0);
    access(0, 32'h20, 4'hF, 0, 32'h11AA3344, 0);
    access(1, 32'h20, 4'b0000, 32'hFFFFFFFF, 0, 0);
    access(0, 32'h20, 4'hF, 0, 32'h11AA3344, 0);

    access(1, 32'h1004, 4'hF, 32'h00000055, 0, 0);
    access(0, 32'h0004, 4'hF, 0, 32'h00000055, 0);

    access(1, 32'h30, 4'hF, 32'h1, 0, 0);
    @(negedge clk);
    ce = 1; we = 1; addr = 32'h30; sel = 4'hF; data = 32'h2;
    @(negedge clk);
    rst = 1;
    ce = 0;
    #1;
    chk("midrst_stall_held", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_ack", {31'd0, ack}, 32'd0);
    chk("midrst_data", data_o, 32'd0);
    rst = 0;
    last_load = 0;
    access(0, 32'h30, 4'hF, 0, 32'h1, 0);

    access(1, 32'h40, 4'hF, 32'h77, 0, 1);
    access(0, 32'h40, 4'hF, 0, 32'h77, 0);

    @(negedge clk);
    ce = 1; we = 0; addr = 32'h10; sel = 4'hF;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    t1 = -1;
    t2 = -1;
    for (int k = 0; k < 30 && t2 < 0; k++) begin
      #1;
      if (ack) begin
        if (t1 < 0) t1 = k;
        else begin
          t2 = k;
          ce = 0;
        end
        chk("b2b_data", data_o, exp_q.pop_front());
      end
      @(negedge clk);
    end
    ce = 0;
    if (t2 < 0) begin
      chk("b2b_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      chk("b2b_first_ack", t1, W + 1);
      chk("b2b_spacing", t2 - t1, W + 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
